// File: rtl/mem_2p_arb.sv
// rtl/mem_2p_arb.sv - two-port word store, shared write port with port-0 priority, deferred port-1 write, clear sweep
// Optional MEM_2P_RDREG_EN: registered read outputs (1-cycle latency).
module mem_2p_arb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    output logic             wack0,
    output logic             wack1,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    input  logic             clr,
    output logic             busy,
    output logic             collide
);
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [AW-1:0]    ptr;
    logic             pend_v;
    logic [AW-1:0]    pend_addr;
    logic [WIDTH-1:0] pend_data;
    logic             collide_q;

    logic             legal0, legal1, accept;
    logic             wr_en, set_pend, set_coll;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd0, rd1;

    // Out-of-range addresses are accepted but never touch or alias a real word.
    assign legal0 = ({1'b0, addr0} < DEPTH_W);
    assign legal1 = ({1'b0, addr1} < DEPTH_W);
    assign accept = (state == S_IDLE) && !pend_v;
    assign wack0  = accept;
    assign wack1  = accept;
    assign busy   = (state == S_CLEAR);
    assign collide = collide_q;

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = ptr;
        wr_data  = '0;
        set_pend = 1'b0;
        set_coll = 1'b0;
        if (state == S_CLEAR) begin
            wr_en = 1'b1;
        end else if (pend_v) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end else if (we0) begin
            wr_en   = legal0;
            wr_addr = addr0;
            wr_data = data_in0;
            if (we1 && legal1) begin
                if (legal0 && (addr0 == addr1)) set_coll = 1'b1;
                else                             set_pend = 1'b1;
            end
        end else if (we1) begin
            wr_en   = legal1;
            wr_addr = addr1;
            wr_data = data_in1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state     <= S_IDLE;
            ptr       <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            collide_q <= 1'b0;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            collide_q <= set_coll;
            if (set_pend) begin
                pend_v    <= 1'b1;
                pend_addr <= addr1;
                pend_data <= data_in1;
            end else if (pend_v && (state == S_IDLE)) begin
                pend_v <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (clr && !pend_v) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    if (ptr == LAST) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            endcase
        end
    end

    // A deferred port-1 write is visible to readers before it reaches the array.
    always_comb begin
        rd0 = '0;
        rd1 = '0;
        if (legal0) rd0 = (pend_v && (addr0 == pend_addr)) ? pend_data : mem[addr0];
        if (legal1) rd1 = (pend_v && (addr1 == pend_addr)) ? pend_data : mem[addr1];
    end

`ifdef MEM_2P_RDREG_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            data_out0 <= '0;
            data_out1 <= '0;
        end else begin
            data_out0 <= rd0;
            data_out1 <= rd1;
        end
    end
`else
    assign data_out0 = rd0;
    assign data_out1 = rd1;
`endif

endmodule
